// File: rtl/mac_array_os.sv
`default_nettype none
// ============================================================================
// Module   : mac_array_os
// Summary  : Output-stationary systolic MAC array with internal input skew,
//            pipeline flush and row-serial result drain.
//            Define MAC_ARRAY_SAT_EN for sticky saturating accumulation.
// Revision : 1.0
// ============================================================================
module mac_array_os #(
    parameter int bw      = 4,
    parameter int psum_bw = 16,
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int k_bw    = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [k_bw-1:0]           k_len,
    output logic                      busy,
    input  logic [row*bw-1:0]         in_w,
    input  logic [col*bw-1:0]         in_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [col*psum_bw-1:0]    out_s,
    output logic [$clog2(row)-1:0]    out_row,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      done
);

    localparam int c_flush_len = row + col - 2;
    localparam int c_fl_w      = $clog2(row + col);
    localparam int c_row_w     = $clog2(row);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t              r_state;
    logic [k_bw-1:0]     r_k_len;
    logic [k_bw-1:0]     r_beat_cnt;
    logic [c_fl_w-1:0]   r_flush_cnt;
    logic [c_row_w-1:0]  r_out_row;

    logic w_beat;
    logic w_adv;
    logic w_clear;
    logic w_last_row;

    // {tag, activation} entering each PE from the west, weight from the north
    logic [bw:0]          w_a_in [row][col];
    logic [bw-1:0]        w_b_in [row][col];
    logic [psum_bw-1:0]   w_acc  [row][col];

    assign busy       = (r_state != S_IDLE);
    assign in_ready   = (r_state == S_LOAD);
    assign out_valid  = (r_state == S_DRAIN);
    assign out_row    = r_out_row;
    assign w_last_row = (r_out_row == c_row_w'(row - 1));
    assign done       = out_valid & out_ready & w_last_row;

    assign w_beat  = in_ready & in_valid;
    assign w_adv   = w_beat | (r_state == S_FLUSH);
    assign w_clear = (r_state == S_IDLE) & start;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_k_len     <= '0;
            r_beat_cnt  <= '0;
            r_flush_cnt <= '0;
            r_out_row   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_k_len     <= k_len;
                        r_beat_cnt  <= '0;
                        r_flush_cnt <= '0;
                        r_out_row   <= '0;
                        r_state     <= (k_len == '0) ? S_DRAIN : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_beat) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                        if (r_beat_cnt == r_k_len - 1'b1)
                            r_state <= (c_flush_len == 0) ? S_DRAIN : S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    r_flush_cnt <= r_flush_cnt + 1'b1;
                    if (r_flush_cnt == c_fl_w'(c_flush_len - 1))
                        r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        if (w_last_row) begin
                            r_out_row <= '0;
                            r_state   <= S_IDLE;
                        end else begin
                            r_out_row <= r_out_row + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Activation skew: lane r sees r beat-stages of delay; tag rides along
    genvar gr, gc;
    generate
        for (gr = 0; gr < row; gr++) begin : g_skew_w
            logic [bw:0] w_src;
            assign w_src = w_beat ? {1'b1, in_w[gr*bw +: bw]} : '0;
            if (gr == 0) begin : g_direct
                assign w_a_in[0][0] = w_src;
            end else begin : g_delay
                logic [bw:0] r_sk [gr];
                always_ff @(posedge clk) begin
                    if (reset || w_clear) begin
                        for (int i = 0; i < gr; i++) r_sk[i] <= '0;
                    end else if (w_adv) begin
                        r_sk[0] <= w_src;
                        for (int i = 1; i < gr; i++) r_sk[i] <= r_sk[i-1];
                    end
                end
                assign w_a_in[gr][0] = r_sk[gr-1];
            end
        end

        for (gc = 0; gc < col; gc++) begin : g_skew_n
            logic [bw-1:0] w_src;
            assign w_src = w_beat ? in_n[gc*bw +: bw] : '0;
            if (gc == 0) begin : g_direct
                assign w_b_in[0][0] = w_src;
            end else begin : g_delay
                logic [bw-1:0] r_sk [gc];
                always_ff @(posedge clk) begin
                    if (reset || w_clear) begin
                        for (int i = 0; i < gc; i++) r_sk[i] <= '0;
                    end else if (w_adv) begin
                        r_sk[0] <= w_src;
                        for (int i = 1; i < gc; i++) r_sk[i] <= r_sk[i-1];
                    end
                end
                assign w_b_in[0][gc] = r_sk[gc-1];
            end
        end

        for (gr = 0; gr < row; gr++) begin : g_pe_row
            for (gc = 0; gc < col; gc++) begin : g_pe_col
                logic signed [psum_bw-1:0] w_a_ext;
                logic signed [psum_bw-1:0] w_b_ext;
                logic signed [psum_bw-1:0] w_prod;
                logic [psum_bw-1:0]        w_acc_next;
                logic [psum_bw-1:0]        r_acc;
                logic                      w_tag;

                assign w_tag   = w_a_in[gr][gc][bw];
                assign w_a_ext = psum_bw'($signed(w_a_in[gr][gc][bw-1:0]));
                assign w_b_ext = psum_bw'($signed(w_b_in[gr][gc]));
                assign w_prod  = w_a_ext * w_b_ext;

`ifdef MAC_ARRAY_SAT_EN
                logic [psum_bw:0] w_sum;
                logic             w_ovf;
                logic             r_sat;
                assign w_sum = {r_acc[psum_bw-1], r_acc} + {w_prod[psum_bw-1], w_prod};
                assign w_ovf = w_sum[psum_bw] ^ w_sum[psum_bw-1];
                assign w_acc_next = !w_ovf ? w_sum[psum_bw-1:0]
                                  : (w_sum[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}}
                                                    : {1'b0, {(psum_bw-1){1'b1}}});
                // Once clamped, the lane is frozen until the next job clears it
                always_ff @(posedge clk) begin
                    if (reset || w_clear) begin
                        r_acc <= '0;
                        r_sat <= 1'b0;
                    end else if (w_adv && w_tag && !r_sat) begin
                        r_acc <= w_acc_next;
                        r_sat <= w_ovf;
                    end
                end
`else
                assign w_acc_next = r_acc + w_prod;
                always_ff @(posedge clk) begin
                    if (reset || w_clear)
                        r_acc <= '0;
                    else if (w_adv && w_tag)
                        r_acc <= w_acc_next;
                end
`endif
                assign w_acc[gr][gc] = r_acc;

                if (gc < col - 1) begin : g_fwd_e
                    logic [bw:0] r_a;
                    always_ff @(posedge clk) begin
                        if (reset || w_clear) r_a <= '0;
                        else if (w_adv)      r_a <= w_a_in[gr][gc];
                    end
                    assign w_a_in[gr][gc+1] = r_a;
                end

                if (gr < row - 1) begin : g_fwd_s
                    logic [bw-1:0] r_b;
                    always_ff @(posedge clk) begin
                        if (reset || w_clear) r_b <= '0;
                        else if (w_adv)      r_b <= w_b_in[gr][gc];
                    end
                    assign w_b_in[gr+1][gc] = r_b;
                end
            end
        end
    endgenerate

    always_comb begin
        out_s = '0;
        for (int c = 0; c < col; c++)
            out_s[c*psum_bw +: psum_bw] = w_acc[r_out_row][c];
    end

endmodule
`default_nettype wire
